// File: rtl/mac_sum_drain_if.sv
// Output stream of the MAC column drain stage.
// Master drives one requantized element per valid/ready beat.
interface mac_sum_drain_if #(
    parameter int WORD_SIZE = 8,
    parameter int NUM_PE    = 4,
    parameter int IDX_W     = $clog2(NUM_PE)
);
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_data;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mac_sum_drain.sv
// Drain stage for one MAC column: snapshot sums on start,
// requantize (shift, round-half-up, saturate) and stream out.
module mac_sum_drain #(
    parameter int WORD_SIZE = 8,
    parameter int NUM_PE    = 4,
    parameter int ACC_W     = 2*WORD_SIZE+1,
    parameter int IDX_W     = $clog2(NUM_PE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_PE*ACC_W-1:0] sin,
    input  logic [3:0]              shift,
    output logic                    busy,
    output logic                    sat_flag,
    output logic                    done,
    mac_sum_drain_if.master         m
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WORD_SIZE-1:0] MAX_V    = '1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_PE-1);

    logic [1:0]           r_state;
    logic [ACC_W-1:0]     r_snap [NUM_PE];
    logic [3:0]           r_shift;
    logic [IDX_W-1:0]     r_idx;
    logic [WORD_SIZE-1:0] r_data;
    logic                 r_valid;
    logic                 r_sat;

    logic [ACC_W-1:0]     w_sin [NUM_PE];
    logic [IDX_W-1:0]     w_next_idx;
    logic [WORD_SIZE:0]   w_first;
    logic [WORD_SIZE:0]   w_next;
    logic                 w_hs;

    // Returns {saturated, value}; one extra bit keeps the rounding carry.
    function automatic logic [WORD_SIZE:0] requant(
        input logic [ACC_W-1:0] s,
        input logic [3:0]       sh
    );
        logic [ACC_W:0] v_rnd;
        logic [ACC_W:0] v_sum;
        logic [ACC_W:0] v_r;
        if (sh == 4'd0) begin
            v_rnd = '0;
        end else begin
            v_rnd = (ACC_W+1)'(1) << (sh - 4'd1);
        end
        v_sum = {1'b0, s} + v_rnd;
        v_r   = v_sum >> sh;
        if (|v_r[ACC_W:WORD_SIZE]) begin
            return {1'b1, MAX_V};
        end
        return {1'b0, v_r[WORD_SIZE-1:0]};
    endfunction

    // Unpack the flattened sums and form both element candidates.
    always_comb begin
        for (int i = 0; i < NUM_PE; i++) begin
            w_sin[i] = sin[i*ACC_W +: ACC_W];
        end
        w_next_idx = r_idx + 1'b1;
        w_first    = requant(w_sin[0], shift);
        w_next     = requant(r_snap[w_next_idx], r_shift);
        w_hs       = r_valid && m.out_ready;
    end

    // Frame FSM, snapshot capture and registered output element.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            for (int i = 0; i < NUM_PE; i++) begin
                r_snap[i] <= '0;
            end
            r_shift <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_snap  <= w_sin;
                        r_shift <= shift;
                        r_idx   <= '0;
                        r_data  <= w_first[WORD_SIZE-1:0];
                        r_sat   <= w_first[WORD_SIZE];
                        r_valid <= 1'b1;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (w_hs) begin
                        if (r_idx == LAST_IDX) begin
                            r_valid <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_idx  <= w_next_idx;
                            r_data <= w_next[WORD_SIZE-1:0];
                            if (w_next[WORD_SIZE]) begin
                                r_sat <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign sat_flag    = r_sat;
    assign m.out_valid = r_valid;
    assign m.out_data  = r_data;
    assign m.out_idx   = r_idx;
    assign m.out_last  = (r_idx == LAST_IDX) && r_valid;
endmodule

// File: tb/tb_mac_sum_drain.sv
// Randomized + directed bench for mac_sum_drain against a
// queue-based frame model.
module tb_mac_sum_drain;
    localparam int W     = 8;
    localparam int N     = 4;
    localparam int ACC_W = 2*W+1;
    localparam int IDX_W = $clog2(N);

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [N*ACC_W-1:0]  sin;
    logic [3:0]          shift;
    logic                busy;
    logic                sat_flag;
    logic                done;

    mac_sum_drain_if #(.WORD_SIZE(W), .NUM_PE(N)) u_if ();

    mac_sum_drain #(.WORD_SIZE(W), .NUM_PE(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sin      (sin),
        .shift    (shift),
        .busy     (busy),
        .sat_flag (sat_flag),
        .done     (done),
        .m        (u_if)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    bit chk_en = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", n, act, exp, $time);
        end
    endtask

    // Reference requantizer in plain integer arithmetic.
    function automatic int rq(input int s, input int sh, output bit sat);
        int r;
        r   = (s + ((sh > 0) ? (1 << (sh - 1)) : 0)) >> sh;
        sat = (r > 255);
        return sat ? 255 : r;
    endfunction

    // Frame model: a queue of pending elements plus done/sat flags.
    int q_data[$];
    bit q_sat[$];
    bit m_done;
    bit m_sat;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_data.delete();
            q_sat.delete();
            m_done = 0;
            m_sat  = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (q_data.size() > 0) begin
            if (u_if.out_ready) begin
                void'(q_data.pop_front());
                void'(q_sat.pop_front());
                if (q_data.size() == 0) m_done = 1;
                else if (q_sat[0]) m_sat = 1;
            end
        end else if (start) begin
            for (int i = 0; i < N; i++) begin
                bit s;
                int v;
                v = rq(int'(sin[i*ACC_W +: ACC_W]), int'(shift), s);
                q_data.push_back(v);
                q_sat.push_back(s);
            end
            m_sat = q_sat[0];
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst && chk_en) begin
            int sz;
            sz = q_data.size();
            chk("busy", busy, (sz > 0 || m_done) ? 1 : 0);
            chk("valid", u_if.out_valid, (sz > 0) ? 1 : 0);
            chk("done", done, m_done ? 1 : 0);
            chk("sat", sat_flag, m_sat ? 1 : 0);
            chk("last", u_if.out_last, (sz == 1) ? 1 : 0);
            if (sz > 0) begin
                chk("data", u_if.out_data, q_data[0]);
                chk("idx", u_if.out_idx, N - sz);
            end
        end
    end

    task automatic set_sin(input int a, input int b, input int c,
                           input int d);
        sin[0*ACC_W +: ACC_W] = ACC_W'(a);
        sin[1*ACC_W +: ACC_W] = ACC_W'(b);
        sin[2*ACC_W +: ACC_W] = ACC_W'(c);
        sin[3*ACC_W +: ACC_W] = ACC_W'(d);
    endtask

    task automatic pulse_start(input int sh, input int a, input int b,
                               input int c, input int d);
        @(posedge clk); #1;
        shift = 4'(sh);
        set_sin(a, b, c, d);
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic lit_frame(input string tag, input int sh, input int a,
                             input int b, input int c, input int d,
                             input int e0, input int e1, input int e2,
                             input int e3, input int es);
        int e [4];
        e = '{e0, e1, e2, e3};
        pulse_start(sh, a, b, c, d);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk({tag, "_data"}, u_if.out_data, e[k]);
            chk({tag, "_idx"}, u_if.out_idx, k);
            chk({tag, "_last"}, u_if.out_last, (k == N-1) ? 1 : 0);
        end
        @(negedge clk);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_sat"}, sat_flag, es);
        @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
    endtask

    function automatic int rnd_sum();
        unique case ($urandom_range(3))
            0: return $urandom_range(255);
            1: return $urandom_range(131071 - 16) + 16;
            2: return 131071 - $urandom_range(20);
            default: return $urandom_range(4095);
        endcase
    endfunction

    initial begin
        rst = 0;
        start = 0;
        shift = 0;
        sin = '0;
        u_if.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", u_if.out_valid, 0);
        chk("rst_data", u_if.out_data, 0);
        chk("rst_idx", u_if.out_idx, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1;
        chk_en = 1;
        repeat (2) @(posedge clk);

        lit_frame("pass", 0, 10, 200, 255, 256, 10, 200, 255, 255, 1);
        lit_frame("round", 4, 24, 23, 8, 7, 2, 1, 1, 0, 0);
        lit_frame("sh9", 9, 131071, 0, 0, 0, 255, 0, 0, 0, 1);
        lit_frame("sh15", 15, 131071, 16383, 0, 16384, 4, 0, 0, 1, 0);

        // Backpressure at idx 1, sin churn and starts while busy.
        pulse_start(4, 24, 23, 8, 7);
        @(negedge clk);
        chk("bp_d0", u_if.out_data, 2);
        @(posedge clk); #1;
        u_if.out_ready = 0;
        start = 1;
        set_sin(131071, 131071, 131071, 131071);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_d", u_if.out_data, 1);
            chk("bp_hold_i", u_if.out_idx, 1);
            @(posedge clk); #1;
            start = 0;
            set_sin($urandom_range(131071), 5, 6, 7);
        end
        u_if.out_ready = 1;
        @(negedge clk);
        chk("bp_d1", u_if.out_idx, 1);
        @(negedge clk);
        chk("bp_d2", u_if.out_data, 1);
        @(posedge clk); #1;
        start = 1;
        @(negedge clk);
        chk("bp_d3", u_if.out_data, 0);
        @(posedge clk); #1;
        start = 1;
        set_sin(99, 99, 99, 99);
        @(negedge clk);
        chk("bp_done", done, 1);
        chk("bp_sat", sat_flag, 0);
        start = 0;
        pulse_start(0, 77, 1, 2, 3);
        @(negedge clk);
        chk("post_done_d", u_if.out_data, 77);
        chk("post_done_v", u_if.out_valid, 1);

        // Reset in the middle of a frame.
        repeat (6) @(posedge clk);
        pulse_start(0, 300, 11, 12, 13);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        chk("mid_idx", u_if.out_idx, 2);
        rst = 0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_valid", u_if.out_valid, 0);
        chk("ar_data", u_if.out_data, 0);
        chk("ar_idx", u_if.out_idx, 0);
        chk("ar_last", u_if.out_last, 0);
        chk("ar_sat", sat_flag, 0);
        chk("ar_done", done, 0);
        @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        chk("post_rst_v", u_if.out_valid, 0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start = ($urandom_range(3) == 0);
            u_if.out_ready = ($urandom_range(3) != 0);
            shift = 4'($urandom_range(15));
            set_sin(rnd_sum(), rnd_sum(), rnd_sum(), rnd_sum());
        end
        @(posedge clk); #1;
        start = 0;
        u_if.out_ready = 1;
        repeat (8) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
